// File: rtl/rom_pkg.sv
// Shared state encoding and elaboration-time helpers for the multiplexed-address ROM burst reader.
package rom_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAN,
        ST_SETUP,
        ST_STROBE,
        ST_POST,
        ST_ACCESS,
        ST_CAPTURE,
        ST_DRAIN
    } rom_state_e;

    // Width of the shared phase timer; wide enough for any practical access time.
    localparam int TMR_W = 16;

    function automatic int ceil_cycles(input int ns, input int period_ns);
        int c;
        c = (ns + period_ns - 1) / period_ns;
        return (c < 1) ? 1 : c;
    endfunction

    // One external latch per address chunk above the low byte that rides the bus directly.
    function automatic int num_latch(input int addr_w, input int bus_w);
        int n;
        n = addr_w / bus_w - 1;
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/rom_burst_reader_if.sv
// Request, byte-stream and ROM-pin signals of the burst reader, bundled with master/slave views.
interface rom_burst_reader_if #(
    parameter int ADDR_W    = 16,
    parameter int BUS_W     = 8,
    parameter int DATA_W    = 8,
    parameter int LEN_W     = 16,
    parameter int NUM_LATCH = 1
);
    logic                 req_valid_in;
    logic                 req_ready_out;
    logic [ADDR_W-1:0]    req_addr_in;
    logic [LEN_W-1:0]     req_len_in;
    logic [BUS_W-1:0]     rom_addr_out;
    logic [NUM_LATCH-1:0] rom_latch_out;
    logic [DATA_W-1:0]    rom_data_in;
    logic [DATA_W-1:0]    data_out;
    logic                 data_valid_out;
    logic                 data_ready_in;
    logic                 data_last_out;
    logic                 busy_out;
    logic                 done_out;

    modport slave (
        input  req_valid_in, req_addr_in, req_len_in, rom_data_in, data_ready_in,
        output req_ready_out, rom_addr_out, rom_latch_out, data_out, data_valid_out,
               data_last_out, busy_out, done_out
    );

    modport master (
        output req_valid_in, req_addr_in, req_len_in, rom_data_in, data_ready_in,
        input  req_ready_out, rom_addr_out, rom_latch_out, data_out, data_valid_out,
               data_last_out, busy_out, done_out
    );
endinterface

// File: rtl/rom_cycle_timer.sv
// Loadable down-counter timing the SETUP, STROBE and ACCESS phases; done marks the final cycle.
module rom_cycle_timer
    import rom_pkg::*;
#(
    parameter int CNT_W = TMR_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/rom_burst_reader.sv
// Burst reader for a parallel ROM with latched upper address chunks; only changed chunks are relatched.
module rom_burst_reader
    import rom_pkg::*;
#(
    parameter int PERIOD_NS = 10,
    parameter int ADDR_W    = 16,
    parameter int BUS_W     = 8,
    parameter int DATA_W    = 8,
    parameter int LEN_W     = 16,
    parameter int SETUP_NS  = 50,
    parameter int HOLD_NS   = 5,
    parameter int ACCESS_NS = 250
) (
    input  logic             clk_in,
    input  logic             rst_in,
    rom_burst_reader_if.slave bus
);
    localparam int NUM_LATCH = num_latch(ADDR_W, BUS_W);
    localparam int KW        = (NUM_LATCH > 1) ? $clog2(NUM_LATCH) : 1;
    localparam logic [TMR_W-1:0] S_CYC = TMR_W'(ceil_cycles(SETUP_NS, PERIOD_NS));
    localparam logic [TMR_W-1:0] H_CYC = TMR_W'(ceil_cycles(HOLD_NS, PERIOD_NS));
    localparam logic [TMR_W-1:0] A_CYC = TMR_W'(ceil_cycles(ACCESS_NS, PERIOD_NS));

    rom_state_e           state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic [KW-1:0]        k_q, k_d;
    logic [BUS_W-1:0]     cache_q [NUM_LATCH];
    logic [BUS_W-1:0]     cache_d [NUM_LATCH];
    logic [NUM_LATCH-1:0] cvld_q, cvld_d;
    logic [BUS_W-1:0]     rom_addr_q, rom_addr_d;
    logic [NUM_LATCH-1:0] latch_q, latch_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 vld_q, vld_d;
    logic                 last_q, last_d;
    logic                 done_q, done_d;

    logic                 tmr_load, tmr_done;
    logic [TMR_W-1:0]     tmr_val;
    logic                 need_any;
    logic [KW-1:0]        need_k;
    logic [BUS_W-1:0]     need_chunk;
    logic                 out_free;
    logic                 load_byte;

    rom_cycle_timer #(.CNT_W(TMR_W)) u_timer (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // Lowest chunk needing a relatch. In POST the chunk being latched counts as already cached,
    // which lets POST double as the planning cycle for the next chunk.
    always_comb begin
        need_any   = 1'b0;
        need_k     = '0;
        need_chunk = '0;
        for (int k = NUM_LATCH - 1; k >= 0; k--) begin
            if ((!cvld_q[k] || (cache_q[k] != addr_q[(k+1)*BUS_W +: BUS_W])) &&
                !((state_q == ST_POST) && (KW'(k) == k_q))) begin
                need_any   = 1'b1;
                need_k     = KW'(k);
                need_chunk = addr_q[(k+1)*BUS_W +: BUS_W];
            end
        end
    end

    assign out_free = !vld_q || bus.data_ready_in;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        k_d        = k_q;
        cache_d    = cache_q;
        cvld_d     = cvld_q;
        rom_addr_d = rom_addr_q;
        data_d     = data_q;
        vld_d      = vld_q;
        last_d     = last_q;
        done_d     = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        load_byte  = 1'b0;

        if (vld_q && bus.data_ready_in) begin
            vld_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid_in) begin
                    if (bus.req_len_in == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d  = bus.req_addr_in;
                        rem_d   = bus.req_len_in;
                        state_d = ST_PLAN;
                    end
                end
            end
            ST_PLAN, ST_POST: begin
                if (state_q == ST_POST) begin
                    for (int k = 0; k < NUM_LATCH; k++) begin
                        if (KW'(k) == k_q) begin
                            cache_d[k] = addr_q[(k+1)*BUS_W +: BUS_W];
                            cvld_d[k]  = 1'b1;
                        end
                    end
                end
                if (need_any) begin
                    k_d        = need_k;
                    rom_addr_d = need_chunk;
                    tmr_load   = 1'b1;
                    tmr_val    = S_CYC;
                    state_d    = ST_SETUP;
                end else begin
                    rom_addr_d = addr_q[BUS_W-1:0];
                    tmr_load   = 1'b1;
                    tmr_val    = A_CYC;
                    state_d    = ST_ACCESS;
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = H_CYC;
                    state_d  = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (tmr_done) begin
                    state_d = ST_POST;
                end
            end
            ST_ACCESS: begin
                if (tmr_done) begin
                    if (out_free) begin
                        load_byte = 1'b1;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (out_free) begin
                    load_byte = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (vld_q && bus.data_ready_in) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_byte) begin
            data_d  = bus.rom_data_in;
            vld_d   = 1'b1;
            last_d  = (rem_q == LEN_W'(1));
            addr_d  = addr_q + ADDR_W'(1);
            rem_d   = rem_q - LEN_W'(1);
            state_d = (rem_q == LEN_W'(1)) ? ST_DRAIN : ST_PLAN;
        end

        latch_d = (state_d == ST_STROBE) ? (NUM_LATCH'(1) << k_d) : '0;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            k_q        <= '0;
            cvld_q     <= '0;
            rom_addr_q <= '0;
            latch_q    <= '0;
            data_q     <= '0;
            vld_q      <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int k = 0; k < NUM_LATCH; k++) begin
                cache_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            k_q        <= k_d;
            cvld_q     <= cvld_d;
            rom_addr_q <= rom_addr_d;
            latch_q    <= latch_d;
            data_q     <= data_d;
            vld_q      <= vld_d;
            last_q     <= last_d;
            done_q     <= done_d;
            cache_q    <= cache_d;
        end
    end

    assign bus.req_ready_out  = (state_q == ST_IDLE);
    assign bus.busy_out       = (state_q != ST_IDLE);
    assign bus.rom_addr_out   = rom_addr_q;
    assign bus.rom_latch_out  = latch_q;
    assign bus.data_out       = data_q;
    assign bus.data_valid_out = vld_q;
    assign bus.data_last_out  = last_q;
    assign bus.done_out       = done_q;
endmodule

// File: tb/tb_rom_burst_reader.sv
// Randomised and directed bench for rom_burst_reader against a byte-level burst/relatch model.
module tb_rom_burst_reader;
    localparam int PERIOD  = 10;
    localparam int A_CYC   = (250 + PERIOD - 1) / PERIOD;
    localparam int S_CYC   = (50 + PERIOD - 1) / PERIOD;
    localparam int H_CYC   = (5 + PERIOD - 1) / PERIOD;
    localparam int RELATCH = S_CYC + H_CYC + 1;

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_pass;
    int   rdy_mode;
    int   acc_cyc;
    int   hs_edge;
    int   done_cyc;
    int   done_cnt;
    int   pulses;
    logic [7:0] ext_hi;
    logic [7:0] m_hi;
    bit         m_vld;
    logic [7:0] got_data[$];
    bit         got_last[$];
    int         rises[$];

    rom_burst_reader_if #(.ADDR_W(16), .BUS_W(8), .DATA_W(8), .LEN_W(16), .NUM_LATCH(1)) bus ();

    rom_burst_reader #(
        .PERIOD_NS(PERIOD), .ADDR_W(16), .BUS_W(8), .DATA_W(8), .LEN_W(16),
        .SETUP_NS(50), .HOLD_NS(5), .ACCESS_NS(250)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    function automatic logic [7:0] rom_fn(input logic [15:0] a);
        return (a[15:8] * 8'd29) ^ (a[7:0] + 8'd3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        clk = 1'b0;
        forever #(PERIOD/2) clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // External address latch and ROM array.
    initial begin
        ext_hi = 8'h00;
        forever begin
            @(posedge clk);
            if (bus.rom_latch_out[0]) ext_hi = bus.rom_addr_out;
        end
    end
    assign bus.rom_data_in = rom_fn({ext_hi, bus.rom_addr_out});

    initial begin
        bus.data_ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.data_ready_in = 1'b1;
                2:       bus.data_ready_in = 1'b0;
                default: bus.data_ready_in = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        logic       prev_vld, prev_rdy, prev_last, prev_latch;
        logic [7:0] prev_data;
        prev_vld = 0; prev_rdy = 0; prev_last = 0; prev_latch = 0; prev_data = 0;
        forever begin
            @(negedge clk);
            if (bus.data_valid_out && !prev_vld) rises.push_back(cyc);
            if (bus.data_valid_out && bus.data_ready_in) begin
                got_data.push_back(bus.data_out);
                got_last.push_back(bus.data_last_out);
                hs_edge = cyc + 1;
            end
            if (bus.rom_latch_out != 0 && !prev_latch) pulses++;
            if (bus.done_out) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_vld && !prev_rdy && !rst) begin
                chk("hold_valid", 32'(bus.data_valid_out), 32'd1);
                chk("hold_data", 32'(bus.data_out), 32'(prev_data));
                chk("hold_last", 32'(bus.data_last_out), 32'(prev_last));
            end
            prev_vld   = bus.data_valid_out;
            prev_rdy   = bus.data_ready_in;
            prev_data  = bus.data_out;
            prev_last  = bus.data_last_out;
            prev_latch = (bus.rom_latch_out != 0);
        end
    end

    task automatic issue(input logic [15:0] a, input int len);
        @(posedge clk);
        #1;
        bus.req_valid_in = 1'b1;
        bus.req_addr_in  = a;
        bus.req_len_in   = 16'(len);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus.req_valid_in = 1'b0;
    endtask

    task automatic run_burst(input logic [15:0] a, input int len, input bit timed, input bit bp);
        int p0, d0, exp_p, t, n, gap;
        int gaps[$];
        logic [15:0] ad;
        bit rel;
        p0 = pulses;
        d0 = done_cnt;
        exp_p = 0;
        got_data.delete();
        got_last.delete();
        rises.delete();
        for (int i = 0; i < len; i++) begin
            ad  = a + 16'(i);
            rel = !m_vld || (m_hi != ad[15:8]);
            if (rel) begin
                exp_p++;
                m_hi  = ad[15:8];
                m_vld = 1'b1;
            end
            gaps.push_back(1 + A_CYC + (rel ? RELATCH : 0));
        end
        issue(a, len);
        if (bp) begin
            t = 0;
            while (got_data.size() < 1 && t < 500) begin @(posedge clk); t++; end
            rdy_mode = 2;
            repeat (100) @(posedge clk);
            rdy_mode = 0;
        end
        t = 0;
        while (done_cnt == d0 && t < 200 * len + 200) begin @(posedge clk); t++; end
        @(posedge clk);
        n = got_data.size();
        chk("nbytes", 32'(n), 32'(len));
        for (int i = 0; i < len && i < n; i++) begin
            chk("byte", 32'(got_data[i]), 32'(rom_fn(a + 16'(i))));
            chk("last", 32'(got_last[i]), 32'(i == len - 1));
        end
        chk("latch_pulses", 32'(pulses - p0), 32'(exp_p));
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        if (timed) begin
            if (len == 0) begin
                chk("len0_done_lat", 32'(done_cyc), 32'(acc_cyc));
            end else begin
                chk("rise_count", 32'(rises.size()), 32'(len));
                for (int i = 0; i < len && i < rises.size(); i++) begin
                    gap = (i == 0) ? rises[0] - acc_cyc : rises[i] - rises[i-1];
                    chk("valid_gap", 32'(gap), 32'(gaps[i]));
                end
                chk("done_lat", 32'(done_cyc), 32'(hs_edge));
            end
        end
        chk("ready_after", 32'(bus.req_ready_out), 32'd1);
        chk("busy_after", 32'(bus.busy_out), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(bus.req_ready_out), 32'd1);
        chk({tag, "_busy"}, 32'(bus.busy_out), 32'd0);
        chk({tag, "_valid"}, 32'(bus.data_valid_out), 32'd0);
        chk({tag, "_latch"}, 32'(bus.rom_latch_out), 32'd0);
        chk({tag, "_addr"}, 32'(bus.rom_addr_out), 32'd0);
        chk({tag, "_data"}, 32'(bus.data_out), 32'd0);
        chk({tag, "_last"}, 32'(bus.data_last_out), 32'd0);
        chk({tag, "_done"}, 32'(bus.done_out), 32'd0);
    endtask

    initial begin
        int t, len;
        logic [15:0] a;
        n_chk = 0; n_pass = 0; rdy_mode = 0;
        done_cnt = 0; pulses = 0; hs_edge = 0; done_cyc = 0; acc_cyc = 0;
        m_hi = 8'h00; m_vld = 1'b0;
        rst = 1'b1;
        bus.req_valid_in = 1'b0;
        bus.req_addr_in  = '0;
        bus.req_len_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;

        run_burst(16'h12FE, 3, 1'b1, 1'b0);
        run_burst(16'h1305, 1, 1'b1, 1'b0);
        run_burst(16'hFFFF, 2, 1'b1, 1'b0);
        run_burst(16'h0040, 0, 1'b1, 1'b0);
        run_burst(16'h2000, 5, 1'b0, 1'b1);

        // Abort a relatch of 0x41 while the cache holds 0x40, then reuse 0x40.
        run_burst(16'h4010, 1, 1'b1, 1'b0);
        issue(16'h4100, 1);
        t = 0;
        while (bus.rom_latch_out == 0 && t < 100) begin @(negedge clk); t++; end
        chk("strobe_seen", 32'(bus.rom_latch_out != 0), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        m_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_burst(16'h4020, 1, 1'b1, 1'b0);

        rdy_mode = 1;
        for (int i = 0; i < 12; i++) begin
            a   = ($urandom_range(0, 2) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
            len = $urandom_range(0, 5);
            run_burst(a, len, 1'b0, 1'b0);
        end
        rdy_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
